// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for the CPU MEM-stage data port.
//               Takes one load/store at a time over a valid/ready handshake,
//               waits a fixed LATENCY, performs the access, and returns read
//               data and error status over a second valid/ready handshake.
//               The memory array is never cleared by reset.
// Ports       : clk                 - clock, rising edge
//               reset_n             - asynchronous active-low reset
//               req_valid/req_ready - request handshake
//               req_write           - 1 = store, 0 = load
//               req_addr            - byte address (wraps modulo DEPTH*4)
//               req_wdata           - store data
//               resp_valid/resp_ready - response handshake
//               resp_rdata          - load data; 0 for stores and errors
//               resp_err            - misaligned access (req_addr[1:0] != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;

  logic [31:0]     mem [DEPTH];

  logic            w_accept;
  logic            w_access;
  logic            w_acc_write;
  logic [AW+1:0]   w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [AW-1:0]   w_idx;
  logic            w_misaligned;
  logic [31:0]     w_rd_result;
  logic            w_unused_addr;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign w_accept   = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge itself, so the
  // live request fields are used instead of the (not yet loaded) latches.
  assign w_acc_write  = (r_state == S_IDLE) ? req_write            : r_write;
  assign w_acc_addr   = (r_state == S_IDLE) ? req_addr[AW+1:0]     : r_addr;
  assign w_acc_wdata  = (r_state == S_IDLE) ? req_wdata            : r_wdata;
  assign w_idx        = w_acc_addr[AW+1:2];
  assign w_misaligned = (w_acc_addr[1:0] != 2'b00);
  assign w_rd_result  = (w_misaligned || w_acc_write) ? 32'h0 : mem[w_idx];

  // Reset gating keeps an accept seen while reset is held from committing
  // a store in the LATENCY==1 configuration.
  assign w_access = reset_n &&
                    (((r_state == S_BUSY) && (r_cnt == 4'd0)) ||
                     ((r_state == S_IDLE) && w_accept && (LATENCY == 1)));

  // Address bits above the array index are ignored (address wraps).
  assign w_unused_addr = ^req_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (w_access && w_acc_write && !w_misaligned) begin
      mem[w_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr[AW+1:0];
            r_wdata <= req_wdata;
            r_cnt   <= c_cnt_init;
            if (LATENCY == 1) begin
              r_state    <= S_RESP;
              resp_rdata <= w_rd_result;
              resp_err   <= w_misaligned;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state    <= S_RESP;
            resp_rdata <= w_rd_result;
            resp_err   <= w_misaligned;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state    <= S_IDLE;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. One instance at
//               LATENCY=4/DEPTH=1024 driven through a scoreboard, plus a
//               LATENCY=1 instance for the single-cycle path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset_n;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;

  int          n_checks;
  int          n_fail;
  exp_t        sb[$];
  logic [31:0] mdl [int];

  data_mem_responder #(.DEPTH(1024), .LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request on the LATENCY=4 instance, check the latency and the
  // scoreboard entry, optionally stall the response for 'hold' cycles.
  task automatic transact(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
    exp_t        e;
    exp_t        got;
    int          lat;
    int          key;
    key = int'((addr >> 2) % 1024);
    if (addr[1:0] != 2'b00) begin
      e.rdata = 32'h0; e.err = 1'b1;
    end else if (wr) begin
      e.rdata = 32'h0; e.err = 1'b0;
      mdl[key] = wd;
    end else begin
      e.rdata = mdl.exists(key) ? mdl[key] : 32'hx;
      e.err = 1'b0;
    end
    sb.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    check("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      got = sb.pop_front();
      check("resp_rdata", resp_rdata, got.rdata);
      check("resp_err", {31'h0, resp_err}, {31'h0, got.err});
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin
          req_valid = 1'b1; req_write = 1'b1;
          req_addr = 32'h10; req_wdata = 32'hBADBAD00;
        end
        if (i == 2) req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("hold_rdata", resp_rdata, got.rdata);
        check("hold_err", {31'h0, resp_err}, {31'h0, got.err});
        check("hold_req_ready", {31'h0, req_ready}, 32'h0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {31'h0, resp_valid}, 32'h0);
    check("post_hs_rdata", resp_rdata, 32'h0);
    check("post_hs_err", {31'h0, resp_err}, 32'h0);
    check("post_hs_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
    check({tag, "_err"}, {31'h0, resp_err}, 32'h0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0; resp_ready1 = 1'b0;
    #2;
    check_reset_outputs("rst");
    check("rst1_req_ready", {31'h0, req_ready1}, 32'h1);
    check("rst1_resp_valid", {31'h0, resp_valid1}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Store then load, misaligned load, load still intact
    transact(1'b1, 32'h10, 32'hDEADBEEF, 0);
    transact(1'b0, 32'h10, 32'h0, 0);
    transact(1'b0, 32'h13, 32'h0, 0);
    transact(1'b0, 32'h10, 32'h0, 0);
    // Misaligned store must not write
    transact(1'b1, 32'h11, 32'h0BAD0BAD, 0);
    // Stalled response; a req_valid pulse during the stall must be ignored
    transact(1'b0, 32'h10, 32'h0, 5);
    transact(1'b0, 32'h10, 32'h0, 0);
    // Address wrap
    transact(1'b1, 32'h1000, 32'h1234, 0);
    transact(1'b0, 32'h0, 32'h0, 0);
    transact(1'b1, 32'h4, 32'hCAFEF00D, 0);
    transact(1'b0, 32'h1004, 32'h0, 0);

    // Reset during an in-flight store abandons it
    transact(1'b1, 32'h20, 32'h0000AAAA, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h00005555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("busy_req_ready", {31'h0, req_ready}, 32'h0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    transact(1'b0, 32'h20, 32'h0, 0);

    // LATENCY=1 instance: response on the cycle after accept
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'h00000077;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    check("l1_store_valid", {31'h0, resp_valid1}, 32'h1);
    check("l1_store_rdata", resp_rdata1, 32'h0);
    check("l1_store_req_ready", {31'h0, req_ready1}, 32'h0);
    resp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready1 = 1'b0;
    check("l1_post_hs_valid", {31'h0, resp_valid1}, 32'h0);
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 32'h4;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    check("l1_load_valid", {31'h0, resp_valid1}, 32'h1);
    check("l1_load_rdata", resp_rdata1, 32'h00000077);
    check("l1_load_err", {31'h0, resp_err1}, 32'h0);
    resp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready1 = 1'b0;

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
